// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, types and helper functions for the AES-128
// inverse cipher.
//   SBOX / INV_SBOX : forward and inverse byte substitution tables
//   RCON            : key-schedule round constants
//   aes_state_t     : 16-byte state, byte 0 in bits [127:120], column-major
//   aes_rk_t        : all 11 round keys, index 0 = cipher key
//   expand_key()    : constant key expansion (evaluated at elaboration)
//   xtime()/gmul()  : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11b)
package aes_pkg;

    typedef logic [0:15][7:0]  aes_state_t;
    typedef logic [0:10][127:0] aes_rk_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (enough for 09/0b/0d/0e) via an xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic aes_rk_t expand_key(input logic [127:0] key);
        logic [0:43][31:0] w;
        logic [31:0]       t;
        aes_rk_t           rk;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                // RotWord then SubWord, then fold in the round constant
                t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]}
                    ^ {RCON[i/4 - 1], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   state_i : input state (byte 0 in [127:120], column-major)
//   rk_i    : round key added after InvSubBytes
//   last_i  : final round, InvMixColumns bypassed
//   state_o : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_i))))
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t   state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output aes_state_t   state_o
);

    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;
    aes_state_t mixed;

    // Byte index is 4*column + row; row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int COL = gi / 4;
        localparam int ROW = gi % 4;
        assign shifted[gi] = state_i[4*((COL - ROW + 4) % 4) + ROW];
        assign subbed[gi]  = INV_SBOX[shifted[gi]];
    end

    assign keyed = subbed ^ rk_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign mixed[4*gi+0] = gmul(keyed[4*gi+0], 4'he) ^ gmul(keyed[4*gi+1], 4'hb)
                             ^ gmul(keyed[4*gi+2], 4'hd) ^ gmul(keyed[4*gi+3], 4'h9);
        assign mixed[4*gi+1] = gmul(keyed[4*gi+0], 4'h9) ^ gmul(keyed[4*gi+1], 4'he)
                             ^ gmul(keyed[4*gi+2], 4'hb) ^ gmul(keyed[4*gi+3], 4'hd);
        assign mixed[4*gi+2] = gmul(keyed[4*gi+0], 4'hd) ^ gmul(keyed[4*gi+1], 4'h9)
                             ^ gmul(keyed[4*gi+2], 4'he) ^ gmul(keyed[4*gi+3], 4'hb);
        assign mixed[4*gi+3] = gmul(keyed[4*gi+0], 4'hb) ^ gmul(keyed[4*gi+1], 4'hd)
                             ^ gmul(keyed[4*gi+2], 4'h9) ^ gmul(keyed[4*gi+3], 4'he);
    end

    assign state_o = last_i ? keyed : mixed;

endmodule

// File: rtl/aes_decryptor.sv
// aes_decryptor: iterative AES-128 inverse cipher with a fixed key.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   data_i, data_v_i    : ciphertext in, accepted when data_v_i & ready_o
//   ready_o             : high in IDLE
//   data_o, data_v_o    : plaintext out, valid in DONE, released by yumi_i
// Build option AES_DEC_TWO_ROUNDS_EN: two inverse rounds per RUN cycle
// (5-cycle latency instead of 10).
module aes_decryptor
    import aes_pkg::*;
#(
    parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] data_i,
    input  logic         data_v_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         data_v_o,
    input  logic         yumi_i
);

    localparam aes_rk_t RK = expand_key(KEY);

    aes_fsm_e     state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d;
    aes_state_t   round_out;

`ifdef AES_DEC_TWO_ROUNDS_EN
    localparam logic [3:0] ROUND_STEP = 4'd2;
    localparam logic [3:0] LAST_ROUND = 4'd1;

    aes_state_t   hi_out;
    logic [127:0] rk_lo;

    // Guarded so the index stays in range while idle with round_q == 0.
    assign rk_lo = (round_q == 4'd0) ? RK[0] : RK[round_q - 4'd1];

    aes_inv_round u_round_hi (
        .state_i (data_q),
        .rk_i    (RK[round_q]),
        .last_i  (1'b0),
        .state_o (hi_out)
    );

    aes_inv_round u_round_lo (
        .state_i (hi_out),
        .rk_i    (rk_lo),
        .last_i  (round_q == 4'd1),
        .state_o (round_out)
    );
`else
    localparam logic [3:0] ROUND_STEP = 4'd1;
    localparam logic [3:0] LAST_ROUND = 4'd0;

    aes_inv_round u_round (
        .state_i (data_q),
        .rk_i    (RK[round_q]),
        .last_i  (round_q == 4'd0),
        .state_o (round_out)
    );
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (data_v_i) begin
                    data_d  = data_i ^ RK[10];
                    round_d = 4'd9;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = round_out;
                if (round_q == LAST_ROUND) begin
                    round_d = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q - ROUND_STEP;
                end
            end
            ST_DONE: begin
                if (yumi_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            data_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign data_v_o = (state_q == ST_DONE);
    assign data_o   = data_q;

endmodule

// File: tb/tb_aes_decryptor.sv
// tb_aes_decryptor: directed bench for aes_decryptor using FIPS-197 vectors.
// Two instances: default key (Appendix B vector) and key 000102..0f
// (Appendix C.1 vector). Honours AES_DEC_TWO_ROUNDS_EN for expected latency.
module tb_aes_decryptor;

`ifdef AES_DEC_TWO_ROUNDS_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 10;
`endif

    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [127:0] a_data_i, b_data_i;
    logic         a_data_v_i, b_data_v_i;
    logic         a_ready_o, b_ready_o;
    logic [127:0] a_data_o, b_data_o;
    logic         a_data_v_o, b_data_v_o;
    logic         a_yumi_i, b_yumi_i;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_decryptor dut_a (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .data_i   (a_data_i),
        .data_v_i (a_data_v_i),
        .ready_o  (a_ready_o),
        .data_o   (a_data_o),
        .data_v_o (a_data_v_o),
        .yumi_i   (a_yumi_i)
    );

    aes_decryptor #(.KEY(128'h000102030405060708090a0b0c0d0e0f)) dut_b (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .data_i   (b_data_i),
        .data_v_i (b_data_v_i),
        .ready_o  (b_ready_o),
        .data_o   (b_data_o),
        .data_v_o (b_data_v_o),
        .yumi_i   (b_yumi_i)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until data_v_o rises (bounded).
    task automatic wait_valid(input bit use_b, output int lat);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (use_b ? b_data_v_o : a_data_v_o) break;
        end
    endtask

    task automatic send_a(input logic [127:0] ct);
        a_data_i   = ct;
        a_data_v_i = 1'b1;
        tick();
        a_data_v_i = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        a_yumi_i = 1'b1;
        tick();
        a_yumi_i = 1'b0;
        check({tag, "_v_after_yumi"}, 128'(a_data_v_o), 128'(1'b0));
        check({tag, "_rdy_after_yumi"}, 128'(a_ready_o), 128'(1'b1));
    endtask

    initial begin
        int lat;
        reset_i    = 1'b1;
        a_data_i   = '0; a_data_v_i = 1'b0; a_yumi_i = 1'b0;
        b_data_i   = '0; b_data_v_i = 1'b0; b_yumi_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;

        check("rst_ready", 128'(a_ready_o), 128'(1'b1));
        check("rst_valid", 128'(a_data_v_o), 128'(1'b0));
        check("rst_data", a_data_o, 128'h0);
        check("rst_b_ready", 128'(b_ready_o), 128'(1'b1));

        // 1: default key, one-cycle valid pulse
        send_a(CT1);
        check("s1_busy", 128'(a_ready_o), 128'(1'b0));
        wait_valid(1'b0, lat);
        $display("s1: latency %0d data %h", lat, a_data_o);
        check("s1_latency", 128'(lat), 128'(LAT));
        check("s1_data", a_data_o, PT1);
        check("s1_ready_done", 128'(a_ready_o), 128'(1'b0));
        drain_a("s1");

        // 2: FIPS-197 C.1 key
        b_data_i   = CT2;
        b_data_v_i = 1'b1;
        tick();
        b_data_v_i = 1'b0;
        wait_valid(1'b1, lat);
        $display("s2: latency %0d data %h", lat, b_data_o);
        check("s2_latency", 128'(lat), 128'(LAT));
        check("s2_data", b_data_o, PT2);
        b_yumi_i = 1'b1;
        tick();
        b_yumi_i = 1'b0;
        check("s2_rdy_after_yumi", 128'(b_ready_o), 128'(1'b1));

        // 3: backpressure, output must hold for 20 cycles
        send_a(CT1);
        wait_valid(1'b0, lat);
        check("s3_latency", 128'(lat), 128'(LAT));
        for (int i = 0; i < 20; i++) begin
            tick();
            check("s3_hold_data", a_data_o, PT1);
            check("s3_hold_valid", 128'(a_data_v_o), 128'(1'b1));
            check("s3_hold_ready", 128'(a_ready_o), 128'(1'b0));
        end
        $display("s3: held %h for 20 cycles", a_data_o);
        drain_a("s3");

        // 4: second ciphertext during RUN and DONE is ignored; then back-to-back
        send_a(CT1);
        a_data_i   = CT2;
        a_data_v_i = 1'b1;
        wait_valid(1'b0, lat);
        check("s4_latency", 128'(lat), 128'(LAT));
        check("s4_data", a_data_o, PT1);
        tick();
        check("s4_done_hold", a_data_o, PT1);
        a_data_v_i = 1'b0;
        $display("s4: busy block ignored, data %h", a_data_o);
        drain_a("s4");
        send_a(CT1);
        wait_valid(1'b0, lat);
        $display("s4: back-to-back latency %0d data %h", lat, a_data_o);
        check("s4_b2b_latency", 128'(lat), 128'(LAT));
        check("s4_b2b_data", a_data_o, PT1);
        drain_a("s4b");

        // 5: reset in the middle of a block
        send_a(CT1);
        for (int i = 0; i < LAT / 2 - 1; i++) tick();
        check("s5_midrun_busy", 128'(a_ready_o), 128'(1'b0));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("s5_rst_ready", 128'(a_ready_o), 128'(1'b1));
        check("s5_rst_valid", 128'(a_data_v_o), 128'(1'b0));
        check("s5_rst_data", a_data_o, 128'h0);
        send_a(CT1);
        wait_valid(1'b0, lat);
        $display("s5: after reset latency %0d data %h", lat, a_data_o);
        check("s5_latency", 128'(lat), 128'(LAT));
        check("s5_data", a_data_o, PT1);
        drain_a("s5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
